// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache flush engine: tag word layout and FSM state codes.
package dcache_pkg;

    localparam int unsigned TAG_VALID_BIT = 23;
    localparam int unsigned TAG_DIRTY_BIT = 22;
    localparam int unsigned TAG_ADDR_W    = 22;
    localparam int unsigned LINE_OFFSET_W = 5;

    // Flush FSM encoding, kept as plain constants for compatibility with older tooling.
    typedef logic [2:0] flush_state_t;

    localparam flush_state_t StIdle   = 3'd0;
    localparam flush_state_t StWaitCc = 3'd1;
    localparam flush_state_t StRead   = 3'd2;
    localparam flush_state_t StCheck  = 3'd3;
    localparam flush_state_t StWrite  = 3'd4;
    localparam flush_state_t StClean  = 3'd5;
    localparam flush_state_t StNext   = 3'd6;
    localparam flush_state_t StDone   = 3'd7;

endpackage

// File: rtl/dcache_mem_port_mux.sv
// Owner select for the Data_Memory port: the cache controller owns it unless the flush
// engine has taken over, in which case the controller sees no ack and no read data.
module dcache_mem_port_mux #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              engine_owns_i,
    input  logic              cc_mem_enable_i,
    input  logic              cc_mem_write_i,
    input  logic [ADDR_W-1:0] cc_mem_addr_i,
    input  logic [LINE_W-1:0] cc_mem_data_i,
    output logic              cc_mem_ack_o,
    output logic [LINE_W-1:0] cc_mem_data_o,
    input  logic              eng_mem_enable_i,
    input  logic              eng_mem_write_i,
    input  logic [ADDR_W-1:0] eng_mem_addr_i,
    input  logic [LINE_W-1:0] eng_mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    // Route the memory port to whichever side currently owns it.
    always_comb begin
        if (engine_owns_i) begin
            mem_enable_o  = eng_mem_enable_i;
            mem_write_o   = eng_mem_write_i;
            mem_addr_o    = eng_mem_addr_i;
            mem_data_o    = eng_mem_data_i;
            cc_mem_ack_o  = 1'b0;
            cc_mem_data_o = '0;
        end else begin
            mem_enable_o  = cc_mem_enable_i;
            mem_write_o   = cc_mem_write_i;
            mem_addr_o    = cc_mem_addr_i;
            mem_data_o    = cc_mem_data_i;
            cc_mem_ack_o  = mem_ack_i;
            cc_mem_data_o = mem_data_i;
        end
    end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Write-back flush engine for the direct-mapped data cache. Walks every line, writes back
// valid+dirty lines to Data_Memory and cleans their tags while stalling the pipeline.
// Build option DCACHE_FLUSH_INVALIDATE_EN: every valid line is cleaned with an all-zero tag,
// leaving the cache empty after the walk.
module dcache_flush_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned INDEX_W   = 5,
    parameter int unsigned TAG_W     = 24,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               flush_done_o,
    output logic [INDEX_W-1:0] sram_index_o,
    output logic               sram_enable_o,
    output logic               sram_write_o,
    output logic [TAG_W-1:0]   sram_tag_o,
    input  logic [TAG_W-1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    input  logic               cc_mem_enable_i,
    input  logic               cc_mem_write_i,
    input  logic [ADDR_W-1:0]  cc_mem_addr_i,
    input  logic [LINE_W-1:0]  cc_mem_data_i,
    output logic               cc_mem_ack_o,
    output logic [LINE_W-1:0]  cc_mem_data_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic               mem_ack_i,
    input  logic [LINE_W-1:0]  mem_data_i
);

    localparam logic [INDEX_W-1:0] LastIndex = INDEX_W'(NUM_LINES - 1);

    flush_state_t        state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   data_q;
    logic [TAG_W-1:0]    clean_tag;
    logic                engine_owns;
    logic                eng_mem_enable;
    logic [ADDR_W-1:0]   eng_mem_addr;

    // Next-state and index sequencing for the line walk.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    // Let an in-flight controller transaction finish before taking the port.
                    state_d = cc_mem_enable_i ? StWaitCc : StRead;
                end
            end
            StWaitCc: begin
                if (!cc_mem_enable_i) begin
                    state_d = StRead;
                end
            end
            StRead: state_d = StCheck;
            StCheck: begin
`ifdef DCACHE_FLUSH_INVALIDATE_EN
                if (tag_q[TAG_VALID_BIT]) begin
                    state_d = tag_q[TAG_DIRTY_BIT] ? StWrite : StClean;
                end else begin
                    state_d = StNext;
                end
`else
                if (tag_q[TAG_VALID_BIT] && tag_q[TAG_DIRTY_BIT]) begin
                    state_d = StWrite;
                end else begin
                    state_d = StNext;
                end
`endif
            end
            StWrite: begin
                if (mem_ack_i) begin
                    state_d = StClean;
                end
            end
            StClean: state_d = StNext;
            StNext: begin
                if (index_q == LastIndex) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = StRead;
                end
            end
            StDone: begin
                index_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and line index.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Capture the tag and line on the SRAM read so they stay stable through write-back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tag_q  <= '0;
            data_q <= '0;
        end else if (state_q == StRead) begin
            tag_q  <= sram_tag_i;
            data_q <= sram_data_i;
        end
    end

    // Tag word written back during CLEAN.
    always_comb begin
`ifdef DCACHE_FLUSH_INVALIDATE_EN
        clean_tag = '0;
`else
        clean_tag                = tag_q;
        clean_tag[TAG_DIRTY_BIT] = 1'b0;
`endif
    end

    // Engine-side outputs decoded from the current state.
    always_comb begin
        stall_o        = (state_q != StIdle) && (state_q != StDone);
        flush_done_o   = (state_q == StDone);
        sram_index_o   = index_q;
        sram_enable_o  = (state_q == StRead) || (state_q == StClean);
        sram_write_o   = (state_q == StClean);
        sram_tag_o     = (state_q == StClean) ? clean_tag : '0;
        engine_owns    = (state_q != StIdle) && (state_q != StWaitCc);
        eng_mem_enable = (state_q == StWrite);
        eng_mem_addr   = {tag_q[TAG_ADDR_W-1:0], index_q, {LINE_OFFSET_W{1'b0}}};
    end

    dcache_mem_port_mux #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_port_mux (
        .engine_owns_i    (engine_owns),
        .cc_mem_enable_i  (cc_mem_enable_i),
        .cc_mem_write_i   (cc_mem_write_i),
        .cc_mem_addr_i    (cc_mem_addr_i),
        .cc_mem_data_i    (cc_mem_data_i),
        .cc_mem_ack_o     (cc_mem_ack_o),
        .cc_mem_data_o    (cc_mem_data_o),
        .eng_mem_enable_i (eng_mem_enable),
        .eng_mem_write_i  (eng_mem_enable),
        .eng_mem_addr_i   (eng_mem_addr),
        .eng_mem_data_i   (data_q),
        .mem_enable_o     (mem_enable_o),
        .mem_write_o      (mem_write_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_ack_i        (mem_ack_i),
        .mem_data_i       (mem_data_i)
    );

endmodule
